// File: rtl/dmem_dump_reader.sv
// Sequential readback engine for the data BRAM debug port, streaming words over valid/ready.
// Optional DUMP_CHECKSUM_EN adds a running modulo-2^DATA_WIDTH sum of transferred words.
module dmem_dump_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_last,
    output logic [DATA_WIDTH-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

    localparam logic [1:0] LAT = 2'(RD_LATENCY);

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] remaining;
    logic [1:0]            lat_cnt;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  aborting;

    assign start_addr = base_addr & ~ADDR_WIDTH'(3);
    assign next_addr  = cur_addr + ADDR_WIDTH'(4);
    assign aborting   = abort && (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = (word_count == '0) ? DONE : READ;
            READ: if (lat_cnt == LAT) next_state = HOLD;
            HOLD: if (m_valid && m_ready) next_state = m_last ? DONE : READ;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (aborting) next_state = IDLE;
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // dbg_addr only moves on edges that enter READ, so the BRAM sees a stable address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_addr  <= '0;
            m_data    <= '0;
            m_addr    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            cur_addr  <= '0;
            remaining <= '0;
            lat_cnt   <= '0;
        end else if (aborting) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr  <= start_addr;
                        remaining <= word_count;
                        lat_cnt   <= '0;
                        if (word_count != '0) dbg_addr <= start_addr;
                    end
                end
                READ: begin
                    if (lat_cnt == LAT) begin
                        m_data  <= dbg_data;
                        m_addr  <= cur_addr;
                        m_valid <= 1'b1;
                        m_last  <= (remaining == ADDR_WIDTH'(1));
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                HOLD: begin
                    if (m_valid && m_ready) begin
                        m_valid   <= 1'b0;
                        m_last    <= 1'b0;
                        remaining <= remaining - ADDR_WIDTH'(1);
                        if (!m_last) begin
                            cur_addr <= next_addr;
                            dbg_addr <= next_addr;
                            lat_cnt  <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sum_q <= '0;
        else if (state == IDLE && start)
            sum_q <= '0;
        else if (state == HOLD && m_valid && m_ready && !abort)
            sum_q <= sum_q + m_data;
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Directed self-checking bench for dmem_dump_reader with a registered (latency 1) BRAM model.
module tb_dmem_dump_reader;

`ifdef DUMP_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [9:0]  word_count;
    logic        abort;
    logic        busy;
    logic        done;
    logic [9:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [9:0]  m_addr;
    logic        m_last;
    logic [31:0] checksum;

    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) dbg_data <= mem[dbg_addr[9:2]];

    dmem_dump_reader #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(32),
        .RD_LATENCY(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base_addr(base_addr),
        .word_count(word_count),
        .abort(abort),
        .busy(busy),
        .done(done),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_addr(m_addr),
        .m_last(m_last),
        .checksum(checksum)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && m_valid !== 1'b1; i++) tick();
        chk({tag, "_valid"}, 32'(m_valid), 32'd1);
    endtask

    task automatic beat(input string tag, input logic [9:0] a, input logic [31:0] d, input logic l);
        wait_valid(tag);
        chk({tag, "_addr"}, 32'(m_addr), 32'(a));
        chk({tag, "_data"}, m_data, d);
        chk({tag, "_last"}, 32'(m_last), 32'(l));
        tick();
    endtask

    task automatic do_start(input logic [9:0] b, input logic [9:0] c);
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_done(input string tag, input logic [31:0] ck);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
        chk({tag, "_checksum"}, checksum, CK_EN ? ck : 32'd0);
        tick();
        chk({tag, "_done_off"}, 32'(done), 32'd0);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | 32'(i);
        mem[0]   = 32'h00000010;
        mem[1]   = 32'h00000020;
        mem[2]   = 32'h00000030;
        mem[3]   = 32'h00000040;
        mem[254] = 32'hAAAA0001;
        mem[255] = 32'hBBBB0002;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
        base_addr = '0; word_count = '0;
        tick(); tick();
        chk("rst_busy",    32'(busy),     32'd0);
        chk("rst_done",    32'(done),     32'd0);
        chk("rst_valid",   32'(m_valid),  32'd0);
        chk("rst_last",    32'(m_last),   32'd0);
        chk("rst_dbgaddr", 32'(dbg_addr), 32'd0);
        chk("rst_mdata",   m_data,        32'd0);
        chk("rst_maddr",   32'(m_addr),   32'd0);
        chk("rst_cksum",   checksum,      32'd0);
        rst_n = 1'b1;
        tick();

        // Basic dump with first-beat latency check
        m_ready = 1'b1;
        do_start(10'h000, 10'd4);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_lat0", 32'(m_valid), 32'd0);
        tick();
        chk("basic_lat1", 32'(m_valid), 32'd0);
        tick();
        chk("basic_lat2", 32'(m_valid), 32'd1);
        beat("basic_b0", 10'h000, 32'h10, 1'b0);
        beat("basic_b1", 10'h004, 32'h20, 1'b0);
        beat("basic_b2", 10'h008, 32'h30, 1'b0);
        beat("basic_b3", 10'h00C, 32'h40, 1'b1);
        chk_done("basic", 32'h000000A0);

        // Back-pressure on beat 2
        do_start(10'h000, 10'd4);
        beat("bp_b0", 10'h000, 32'h10, 1'b0);
        m_ready = 1'b0;
        wait_valid("bp_hold");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid_held", 32'(m_valid), 32'd1);
            chk("bp_data_held",  m_data,       32'h20);
            chk("bp_addr_held",  32'(m_addr),  32'h004);
        end
        m_ready = 1'b1;
        beat("bp_b1", 10'h004, 32'h20, 1'b0);
        beat("bp_b2", 10'h008, 32'h30, 1'b0);
        beat("bp_b3", 10'h00C, 32'h40, 1'b1);
        chk_done("bp", 32'h000000A0);

        // Wrap, with unaligned base masked down to 0x3F8
        do_start(10'h3FB, 10'd3);
        chk("wrap_dbgaddr", 32'(dbg_addr), 32'h3F8);
        beat("wrap_b0", 10'h3F8, 32'hAAAA0001, 1'b0);
        beat("wrap_b1", 10'h3FC, 32'hBBBB0002, 1'b0);
        beat("wrap_b2", 10'h000, 32'h00000010, 1'b1);
        chk_done("wrap", 32'h66650013);

        // Zero count
        do_start(10'h010, 10'd0);
        chk("zero_valid", 32'(m_valid), 32'd0);
        chk_done("zero", 32'd0);

        // Abort in HOLD of beat 2 with m_ready high, then restart
        do_start(10'h000, 10'd4);
        beat("ab_b0", 10'h000, 32'h10, 1'b0);
        wait_valid("ab_hold");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_valid", 32'(m_valid), 32'd0);
        chk("ab_last",  32'(m_last),  32'd0);
        chk("ab_busy",  32'(busy),    32'd0);
        chk("ab_done",  32'(done),    32'd0);
        chk("ab_cksum", checksum, CK_EN ? 32'h10 : 32'd0);
        tick();
        chk("ab_done_later", 32'(done), 32'd0);
        do_start(10'h008, 10'd2);
        beat("rs_b0", 10'h008, 32'h30, 1'b0);
        beat("rs_b1", 10'h00C, 32'h40, 1'b1);
        chk_done("rs", 32'h00000070);

        // Start while busy is ignored
        do_start(10'h000, 10'd4);
        beat("ig_b0", 10'h000, 32'h10, 1'b0);
        do_start(10'h100, 10'd1);
        beat("ig_b1", 10'h004, 32'h20, 1'b0);
        beat("ig_b2", 10'h008, 32'h30, 1'b0);
        beat("ig_b3", 10'h00C, 32'h40, 1'b1);
        chk_done("ig", 32'h000000A0);

        // Asynchronous reset mid-READ
        do_start(10'h3F8, 10'd3);
        beat("rr_b0", 10'h3F8, 32'hAAAA0001, 1'b0);
        chk("rr_pre_dbgaddr", 32'(dbg_addr), 32'h3FC);
        rst_n = 1'b0;
        #2;
        chk("rr_busy",    32'(busy),     32'd0);
        chk("rr_done",    32'(done),     32'd0);
        chk("rr_valid",   32'(m_valid),  32'd0);
        chk("rr_last",    32'(m_last),   32'd0);
        chk("rr_dbgaddr", 32'(dbg_addr), 32'd0);
        chk("rr_mdata",   m_data,        32'd0);
        chk("rr_maddr",   32'(m_addr),   32'd0);
        chk("rr_cksum",   checksum,      32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("rr_stay_idle", 32'(m_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
